// File: rtl/carregador_de_instrucoes_if.sv
// ---------------------------------------------------------------------------
// carregador_de_instrucoes_if
//
// Bundles the two buses of the program loader:
//   - byte stream : byte_dado / byte_valido from the source, byte_pronto back
//   - memory write: escrita_habilitada / endereco_escrita / dado_escrita
//
// Modports:
//   master : the environment side (stream source plus memory that takes writes)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface carregador_de_instrucoes_if #(
  parameter int ADDR_WIDTH = 26
);
  logic [7:0]            byte_dado;
  logic                  byte_valido;
  logic                  byte_pronto;
  logic                  escrita_habilitada;
  logic [ADDR_WIDTH-1:0] endereco_escrita;
  logic [31:0]           dado_escrita;

  modport master (
    output byte_dado, byte_valido,
    input  byte_pronto, escrita_habilitada, endereco_escrita, dado_escrita
  );

  modport slave (
    input  byte_dado, byte_valido,
    output byte_pronto, escrita_habilitada, endereco_escrita, dado_escrita
  );
endinterface

// File: rtl/carregador_de_instrucoes.sv
// ---------------------------------------------------------------------------
// carregador_de_instrucoes
//
// Run-time program loader for the instruction memory. It takes a byte stream
// made of a 2-byte word count N (high byte first) followed by N big-endian
// 32-bit words, and writes each word at consecutive addresses from 0. The CPU
// is held through `carregando` while loading; `concluido` flags a complete
// load and `erro` a rejected header (N == 0 or N > MEM_SIZE).
//
// Ports:
//   clock               system clock, rising edge
//   reset               synchronous, active-low
//   iniciar             start strobe (honoured when idle, done or in error)
//   bus (slave)         byte stream in / memory write strobe, address, data
//   carregando          load in progress
//   concluido           all N words written (sticky until restart)
//   erro                header rejected (sticky until restart)
//   palavras_carregadas words written so far
// ---------------------------------------------------------------------------
module carregador_de_instrucoes #(
  parameter int MEM_SIZE   = 150,
  parameter int ADDR_WIDTH = 26
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iniciar,
  carregador_de_instrucoes_if.slave   bus,
  output logic                        carregando,
  output logic                        concluido,
  output logic                        erro,
  output logic [15:0]                 palavras_carregadas
);

  localparam logic [15:0] MEM_SIZE_W = 16'(MEM_SIZE);

  typedef enum logic [2:0] {
    OCIOSO,
    CAB_ALTO,
    CAB_BAIXO,
    VALIDA,
    RECEBE,
    ESCREVE,
    CONCLUIDO,
    ERRO
  } estado_t;

  estado_t     estado, estado_prox;
  logic [15:0] n_palavras;
  logic [23:0] montagem;    // only the three older bytes are ever needed
  logic [1:0]  indice;
  logic [15:0] contagem;    // doubles as the write address: both advance together
  logic [31:0] dado_q;
  logic        aceita;
  logic        transferencia;
  logic [15:0] contagem_inc;

  assign aceita        = (estado == CAB_ALTO) || (estado == CAB_BAIXO) || (estado == RECEBE);
  assign transferencia = aceita && bus.byte_valido;
  assign contagem_inc  = contagem + 16'd1;

  assign bus.byte_pronto      = aceita;
  assign bus.endereco_escrita = {{(ADDR_WIDTH-16){1'b0}}, contagem};
  assign bus.dado_escrita     = dado_q;
  assign palavras_carregadas  = contagem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    estado_prox                = estado;
    bus.escrita_habilitada     = 1'b0;
    carregando                 = 1'b0;
    concluido                  = 1'b0;
    erro                       = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (iniciar) estado_prox = CAB_ALTO;
      end
      CAB_ALTO: begin
        carregando = 1'b1;
        if (transferencia) estado_prox = CAB_BAIXO;
      end
      CAB_BAIXO: begin
        carregando = 1'b1;
        if (transferencia) estado_prox = VALIDA;
      end
      VALIDA: begin
        carregando = 1'b1;
        if (n_palavras == 16'd0 || n_palavras > MEM_SIZE_W) estado_prox = ERRO;
        else                                                estado_prox = RECEBE;
      end
      RECEBE: begin
        carregando = 1'b1;
        if (transferencia && indice == 2'd3) estado_prox = ESCREVE;
      end
      ESCREVE: begin
        carregando             = 1'b1;
        bus.escrita_habilitada = 1'b1;
        if (contagem_inc == n_palavras) estado_prox = CONCLUIDO;
        else                            estado_prox = RECEBE;
      end
      CONCLUIDO: begin
        concluido = 1'b1;
        if (iniciar) estado_prox = CAB_ALTO;
      end
      ERRO: begin
        erro = 1'b1;
        if (iniciar) estado_prox = CAB_ALTO;
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // NOTE: only the loader's own registers are reset here; the instruction
  // memory it feeds is never cleared, so an aborted load leaves whatever words
  // were already written.
  always_ff @(posedge clock) begin
    if (!reset) begin
      n_palavras <= '0;
      montagem   <= '0;
      indice     <= '0;
      contagem   <= '0;
      dado_q     <= '0;
    end else begin
      unique case (estado)
        OCIOSO, CONCLUIDO, ERRO: begin
          if (iniciar) begin
            contagem <= '0;
            indice   <= '0;
          end
        end
        CAB_ALTO:  if (transferencia) n_palavras[15:8] <= bus.byte_dado;
        CAB_BAIXO: if (transferencia) n_palavras[7:0]  <= bus.byte_dado;
        VALIDA:    indice <= '0;
        RECEBE: begin
          if (transferencia) begin
            montagem <= {montagem[15:0], bus.byte_dado};
            indice   <= indice + 2'd1;
            // The last byte completes the word; latch it so the write data
            // stays put until the next word is finished.
            if (indice == 2'd3) dado_q <= {montagem, bus.byte_dado};
          end
        end
        ESCREVE:   contagem <= contagem_inc;
        default:   ;
      endcase
    end
  end

endmodule

// File: doc/carregador_de_instrucoes.md
# carregador_de_instrucoes

Program loader that writes the instruction memory at run time instead of relying on contents fixed at elaboration. It accepts a byte stream with a valid/ready handshake, for example from a UART receiver. It assembles big-endian 32-bit instruction words and issues single-cycle writes at consecutive addresses starting at 0. While loading, it holds the CPU through `carregando`; when finished, it releases it with `concluido`.

## Interface
- `MEM_SIZE`, 150, number of instruction words in the target memory; largest legal word count.
- `ADDR_WIDTH`, 26, width of the write address; matches the PC width.

Ports:
- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `iniciar`  in  1  start strobe, sampled on the rising edge.
- `byte_dado`  in  8  incoming stream byte.
- `byte_valido`  in  1  `byte_dado` is valid.
- `byte_pronto`  out  1  loader can accept a byte this cycle.
- `escrita_habilitada`  out  1  write strobe to instruction memory, one cycle per word.
- `endereco_escrita`  out  ADDR_WIDTH  word address for the write.
- `dado_escrita`  out  32  instruction word to write.
- `carregando`  out  1  load in progress; CPU must be held.
- `concluido`  out  1  sticky; all words written.
- `erro`  out  1  sticky; header rejected.
- `palavras_carregadas`  out  16  count of words written so far.

## Operation
- Stream format: 2-byte header N (high byte first), followed by N words of 4 bytes each, most-significant byte first.
- A byte transfers on a rising edge where `byte_valido` and `byte_pronto` are both 1. No transfer takes place on any other edge, and `byte_dado` is ignored.

State machine:
- OCIOSO: if `iniciar`=1, go to CAB_ALTO. Clear `concluido`, `erro`, `palavras_carregadas`, the address and the byte index.
- CAB_ALTO: on transfer, N[15:8] <= byte; go to CAB_BAIXO.
- CAB_BAIXO: on transfer, N[7:0] <= byte; go to VALIDA.
- VALIDA (1 cycle): if N==0 or N>MEM_SIZE, go to ERRO; otherwise go to RECEBE with byte index 0.
- RECEBE: on transfer, shift the byte into the 32-bit assembly register (`word <= {word[23:0], byte}`) and increment the byte index (2 bits). On the transfer that completes byte index 3, go to ESCREVE.
- ESCREVE (1 cycle): `escrita_habilitada`=1. `endereco_escrita` holds the current address and `dado_escrita` holds the assembled word.
  - On the following edge: address+1, `palavras_carregadas`+1.
  - If the new count == N, go to CONCLUIDO; otherwise go to RECEBE.
- CONCLUIDO: `concluido`=1. `iniciar`=1 restarts, behaving as in OCIOSO.
- ERRO: `erro`=1. Nothing is written. `iniciar`=1 restarts, behaving as in OCIOSO.

Signal rules:
- `iniciar` is ignored in CAB_ALTO through ESCREVE.
- `byte_pronto`=1 only in CAB_ALTO, CAB_BAIXO and RECEBE. It is 0 in VALIDA and ESCREVE, so there is backpressure for exactly one cycle per word.
- `carregando`=1 in CAB_ALTO through ESCREVE; it is 0 otherwise.
- Address width rule: the internal counter is 16 bits. `endereco_escrita` is that counter zero-extended to ADDR_WIDTH. No wrap is possible because N ≤ MEM_SIZE.
- `dado_escrita` holds its last value outside ESCREVE. The memory must qualify writes with `escrita_habilitada` only.

## Timing
- Reset (`reset`=0 at an edge):
  - State becomes OCIOSO.
  - All outputs become 0, including `concluido`, `erro`, `endereco_escrita`, `dado_escrita` and `palavras_carregadas`.
  - Internal N, word register and byte index are cleared.
- Reset mid-load aborts immediately. Partially written memory contents are left as is.
- Reset has priority over `iniciar` and over any transfer on the same edge.
- Latency from `iniciar` to the first `byte_pronto`: 1 cycle.
- Header: 2 transfers, then 1 cycle in VALIDA.
- Per word: 4 transfers, then 1 ESCREVE cycle. The minimum is 5 cycles per word with a continuous `byte_valido`.
- `concluido` rises on the edge after the final ESCREVE cycle.
- `erro` rises on the edge after VALIDA.
- `byte_valido` held high while `byte_pronto`=0: the byte is not consumed, and the source must keep it stable.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with random inputs. All outputs must be 0 and the state OCIOSO; `byte_pronto`=0.
- Nominal load: pulse `iniciar`, then stream 00 02 / 2C 00 00 2D / 08 63 00 06 with `byte_valido` held high.
  - Exactly two write strobes: addr 0 = 0x2C00002D and addr 1 = 0x08630006.
  - `byte_pronto` drops for one cycle after every 4th byte.
  - `concluido`=1 and `palavras_carregadas`=2; `carregando` falls on the same edge.
- Stalled stream: same data as the nominal load, with `byte_valido` toggling pseudo-randomly. Same writes must occur; no byte may be duplicated or dropped.
- Header errors:
  - N=0x0000 gives `erro`=1 with no write.
  - N=151 (00 97) gives `erro`=1 with no write and `byte_pronto`=0 afterwards.
  - N=150 is accepted and writes addresses 0..149.
- Abort and restart:
  - Drop `reset` after 6 bytes of a 3-word load. Outputs must clear, and there must be no further writes.
  - Then run a full 1-word load, which must write addr 0 correctly.
- Restart from CONCLUIDO: `iniciar` in CONCLUIDO clears `concluido` and `palavras_carregadas` on the next edge. `iniciar` pulsed during RECEBE has no effect.
